// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment display stage.
// Segment patterns are ordered {g,f,e,d,c,b,a} and are active-low.
package seg_scan_driver_pkg;

    localparam int SLOT_W = 2;

    typedef logic [SLOT_W-1:0] slot_t;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] AN_OFF   = 4'b1111;

endpackage

// File: rtl/seg_scan_driver_seg_decoder.sv
// BCD-to-7-segment decoder with a blank override; non-BCD codes show a dash.
module seg_decoder
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] value_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        if (blank_i) begin
            seg_o = SEG_OFF;
        end else begin
            case (value_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver with guard cycles,
// frame-synchronous digit capture, leading-zero blanking and per-digit blink.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2,
    parameter int BLINK_DIV   = 64
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic [3:0] y1,
    input  logic [3:0] y2,
    input  logic [3:0] y3,
    input  logic [3:0] y4,
    input  logic       blank_lz,
    input  logic [3:0] blink_en,
    input  logic [3:0] dp_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_END = PW'(GUARD);
    localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_DIV - 1);

    logic [PW-1:0]      pcnt_q, pcnt_d;
    slot_t              slot_q, slot_d;
    logic [BW-1:0]      bcnt_q, bcnt_d;
    logic               phase_q, phase_d;
    logic [3:0][3:0]    shadow_q, shadow_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    logic               tick;
    logic               in_guard;
    logic [3:0]         cur_digit;
    logic [3:0]         digit_zero;
    logic               lz_blank;
    logic               digit_blank;
    logic [6:0]         dec_seg;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            pcnt_q   <= '0;
            slot_q   <= '0;
            bcnt_q   <= '0;
            phase_q  <= 1'b0;
            shadow_q <= '0;
            an_q     <= AN_OFF;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
        end else begin
            pcnt_q   <= pcnt_d;
            slot_q   <= slot_d;
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign tick = (pcnt_q == PCNT_LAST);

    // Digits load only as slot 3 wraps to 0, so a frame never mixes old and new values.
    always_comb begin
        pcnt_d   = tick ? '0 : pcnt_q + PW'(1);
        slot_d   = tick ? slot_q + slot_t'(1) : slot_q;
        shadow_d = shadow_q;
        bcnt_d   = bcnt_q;
        phase_d  = phase_q;
        if (tick && (slot_q == slot_t'(3))) begin
            shadow_d = {y4, y3, y2, y1};
        end
        if (tick) begin
            if (bcnt_q == BCNT_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + BW'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            digit_zero[i] = (shadow_q[i] == 4'd0);
        end
        cur_digit = shadow_q[slot_q];
        case (slot_q)
            2'd3:    lz_blank = digit_zero[3];
            2'd2:    lz_blank = digit_zero[3] & digit_zero[2];
            2'd1:    lz_blank = digit_zero[3] & digit_zero[2] & digit_zero[1];
            default: lz_blank = 1'b0;
        endcase
        digit_blank = (blank_lz & lz_blank) | (blink_en[slot_q] & phase_q);
    end

    seg_decoder u_seg_decoder (
        .value_i (cur_digit),
        .blank_i (digit_blank),
        .seg_o   (dec_seg)
    );

    // The first GUARD cycles of every slot keep all anodes dark to avoid ghosting.
    assign in_guard = (pcnt_q < GUARD_END);

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (!in_guard) begin
            an_d  = ~(4'b0001 << slot_q);
            seg_d = dec_seg;
            dp_d  = digit_blank | ~dp_en[slot_q];
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with REFRESH_DIV=4, GUARD=1, BLINK_DIV=2.
// idx is the scan index (pcnt + 4*slot + 16*frame) that the sampled outputs show.
module tb_seg_scan_driver;

    localparam int RD = 4;
    localparam int GD = 1;
    localparam int BD = 2;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SO = 7'b1111111;

    // {y4,y3,y2,y1}, blank_lz, expected segs {slot3,slot2,slot1,slot0}
    localparam logic [15:0] LZ_Y   [3] = '{16'h0005, 16'h0305, 16'h0005};
    localparam logic        LZ_EN  [3] = '{1'b1, 1'b1, 1'b0};
    localparam logic [27:0] LZ_SEG [3] = '{{SO, SO, SO, S5}, {SO, S3, S0, S5}, {S0, S0, S0, S5}};

    // Blink phase is 0 during slots 0-1 and 1 during slots 2-3 of every frame.
    localparam logic [3:0]  BL_EN  [3] = '{4'b0100, 4'b1111, 4'b0000};
    localparam logic [3:0]  BL_DP  [3] = '{4'b0100, 4'b1111, 4'b0100};
    localparam logic [27:0] BL_SEG [3] = '{{S1, SO, S3, S4}, {SO, SO, S3, S4}, {S1, S2, S3, S4}};
    localparam logic [3:0]  BL_DPL [3] = '{4'b1111, 4'b1100, 4'b1011};

    logic       clk_in = 1'b0;
    logic       rst;
    logic [3:0] y1, y2, y3, y4;
    logic       blank_lz;
    logic [3:0] blink_en, dp_en;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int checks = 0;
    int passes = 0;
    int idx    = 0;

    seg_scan_driver #(
        .REFRESH_DIV (RD),
        .GUARD       (GD),
        .BLINK_DIV   (BD)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .y1       (y1),
        .y2       (y2),
        .y3       (y3),
        .y4       (y4),
        .blank_lz (blank_lz),
        .blink_en (blink_en),
        .dp_en    (dp_en),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    always #5 clk_in = ~clk_in;

    // Expected {an,seg,dp} at scan index n for a frame showing segs with per-slot dp levels dpl.
    function automatic logic [11:0] exp_out(input int n, input logic [27:0] segs, input logic [3:0] dpl);
        int slot;
        slot = (n / 4) % 4;
        if ((n % 4) < GD) return 12'hFFF;
        return {~(4'b0001 << slot), segs[slot*7 +: 7], dpl[slot]};
    endfunction

    task automatic cycle();
        @(posedge clk_in);
        @(negedge clk_in);
        idx++;
    endtask

    task automatic to_frame_end();
        while ((idx % 16) != 15) cycle();
    endtask

    task automatic test_reset();
        logic [11:0] e;
        rst = 1'b0;
        {y4, y3, y2, y1} = 16'h1234;
        blank_lz = 1'b0;
        blink_en = 4'b0000;
        dp_en    = 4'b0000;
        repeat (3) begin
            @(negedge clk_in);
            checks++;
            if ({an, seg, dp} !== 12'hFFF)
                $display("FAIL reset_hold got an=%b seg=%b dp=%b expected an=1111 seg=1111111 dp=1", an, seg, dp);
            else passes++;
        end
        rst = 1'b1;
        idx = -1;
        for (int c = 0; c < 16; c++) begin
            cycle();
            e = exp_out(idx, {S0, S0, S0, S0}, 4'hF);
            checks++;
            if ({an, seg, dp} !== e)
                $display("FAIL reset_zero_frame idx=%0d got %b_%b_%b expected %b", idx, an, seg, dp, e);
            else passes++;
        end
    endtask

    task automatic test_scan();
        logic [11:0] e;
        for (int c = 0; c < 16; c++) begin
            cycle();
            e = exp_out(idx, {S1, S2, S3, S4}, 4'hF);
            checks++;
            if ({an, seg, dp} !== e)
                $display("FAIL scan idx=%0d got %b_%b_%b expected %b", idx, an, seg, dp, e);
            else passes++;
        end
    endtask

    task automatic test_tear_free();
        logic [11:0] e;
        for (int c = 0; c < 32; c++) begin
            cycle();
            e = exp_out(idx, (idx < 48) ? {S1, S2, S3, S4} : {S1, S2, S7, S9}, 4'hF);
            checks++;
            if ({an, seg, dp} !== e)
                $display("FAIL tear_free idx=%0d got %b_%b_%b expected %b", idx, an, seg, dp, e);
            else passes++;
            if (c == 5) begin
                y1 = 4'd9;
                y2 = 4'd7;
            end
        end
    endtask

    task automatic test_lz_blanking();
        logic [11:0] e;
        for (int v = 0; v < 3; v++) begin
            to_frame_end();
            {y4, y3, y2, y1} = LZ_Y[v];
            blank_lz = LZ_EN[v];
            repeat (16) cycle();
            for (int c = 0; c < 16; c++) begin
                cycle();
                e = exp_out(idx, LZ_SEG[v], 4'hF);
                checks++;
                if ({an, seg, dp} !== e)
                    $display("FAIL lz_blank v=%0d idx=%0d got %b_%b_%b expected %b", v, idx, an, seg, dp, e);
                else passes++;
            end
        end
    endtask

    task automatic test_dash();
        logic [11:0] e;
        to_frame_end();
        {y4, y3, y2, y1} = 16'hF8C1;
        blank_lz = 1'b0;
        repeat (16) cycle();
        for (int c = 0; c < 16; c++) begin
            cycle();
            e = exp_out(idx, {SD, S8, SD, S1}, 4'hF);
            checks++;
            if ({an, seg, dp} !== e)
                $display("FAIL dash idx=%0d got %b_%b_%b expected %b", idx, an, seg, dp, e);
            else passes++;
        end
    endtask

    task automatic test_blink_dp();
        logic [11:0] e;
        for (int v = 0; v < 3; v++) begin
            to_frame_end();
            {y4, y3, y2, y1} = 16'h1234;
            blink_en = BL_EN[v];
            dp_en    = BL_DP[v];
            repeat (16) cycle();
            for (int c = 0; c < 16; c++) begin
                cycle();
                e = exp_out(idx, BL_SEG[v], BL_DPL[v]);
                checks++;
                if ({an, seg, dp} !== e)
                    $display("FAIL blink_dp v=%0d idx=%0d got %b_%b_%b expected %b", v, idx, an, seg, dp, e);
                else passes++;
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [11:0] e;
        to_frame_end();
        while ((idx % 16) != 9) cycle();
        checks++;
        if ({an, seg, dp} !== {4'b1011, S2, 1'b0})
            $display("FAIL mid_reset_pre got %b_%b_%b expected 1011_0100100_0", an, seg, dp);
        else passes++;
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({an, seg, dp} !== 12'hFFF)
            $display("FAIL mid_reset_async got an=%b seg=%b dp=%b expected all off", an, seg, dp);
        else passes++;
        dp_en = 4'b0000;
        repeat (2) begin
            @(negedge clk_in);
            checks++;
            if ({an, seg, dp} !== 12'hFFF)
                $display("FAIL mid_reset_hold got an=%b seg=%b dp=%b expected all off", an, seg, dp);
            else passes++;
        end
        rst = 1'b1;
        idx = -1;
        for (int c = 0; c < 32; c++) begin
            cycle();
            e = exp_out(idx, (idx < 16) ? {S0, S0, S0, S0} : {S1, S2, S3, S4}, 4'hF);
            checks++;
            if ({an, seg, dp} !== e)
                $display("FAIL mid_reset_restart idx=%0d got %b_%b_%b expected %b", idx, an, seg, dp, e);
            else passes++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_scan();
        test_tear_free();
        test_lz_blanking();
        test_dash();
        test_blink_dp();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
